// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the 8-tap FIR controller
package fir_pkg;

    localparam int FIR_NTAP = 8;
    localparam int FIR_DW   = 32;
    localparam int FIR_AW   = 3;

    // IEEE-754 single +0.0
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } fir_state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - shadow/active coefficient register banks
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   wr_en/addr/data    shadow write port (addresses >= NTAP are dropped)
//   commit             copy shadow (with any same-cycle write) to active
//   coef_out           active bank, word 0 in the low DW bits
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int NTAP = FIR_NTAP,
    parameter int DW   = FIR_DW,
    parameter int AW   = FIR_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DW-1:0]      wr_data,
    input  logic               commit,
    output logic [NTAP*DW-1:0] coef_out
);

    logic [DW-1:0] shadow     [NTAP];
    logic [DW-1:0] active     [NTAP];
    logic [DW-1:0] shadow_nxt [NTAP];

    // The write is merged before the commit samples it, so a write and a
    // commit in the same cycle land together in the active bank. An address
    // that matches no tap index simply updates nothing.
    always_comb begin
        for (int i = 0; i < NTAP; i++) begin
            shadow_nxt[i] = shadow[i];
            if (wr_en && (wr_addr == AW'(i))) begin
                shadow_nxt[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NTAP; i++) begin
                shadow[i] <= shadow_nxt[i];
                if (commit) begin
                    active[i] <= shadow_nxt[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NTAP; g++) begin : g_flat
        assign coef_out[g*DW +: DW] = active[g];
    end

endmodule

// File: rtl/fir_tap_ctrl8.sv
// rtl/fir_tap_ctrl8.sv - sequencer and coefficient manager for the 8-tap FIR
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_data/in_ready     sample input stream
//   cfg_valid/addr/data           coefficient write to shadow bank
//   cfg_commit/cfg_ready          promote shadow to active, handshake
//   x_out                         registered sample to datapath (0.0 on gaps)
//   coef_out                      active bank, b1 in low word
//   out_valid                     datapath output valid this cycle
//   busy                          delay-line flush in progress
module fir_tap_ctrl8
    import fir_pkg::*;
#(
    parameter int NTAP = FIR_NTAP,
    parameter int DW   = FIR_DW,
    parameter int AW   = FIR_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DW-1:0]      in_data,
    output logic               in_ready,
    input  logic               cfg_valid,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [DW-1:0]      cfg_data,
    input  logic               cfg_commit,
    output logic               cfg_ready,
    output logic [DW-1:0]      x_out,
    output logic [NTAP*DW-1:0] coef_out,
    output logic               out_valid,
    output logic               busy
);

    fir_state_t    state, state_nxt;
    logic [AW-1:0] flush_cnt, flush_cnt_nxt;
    logic          cfg_wr;
    logic          cfg_cm;

    assign cfg_wr = cfg_valid  & cfg_ready;
    assign cfg_cm = cfg_commit & cfg_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        in_ready      = 1'b0;
        cfg_ready     = 1'b1;
        busy          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_cm) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = '0;
                end
            end
            ST_FLUSH: begin
                cfg_ready = 1'b0;
                busy      = 1'b1;
                if (flush_cnt == AW'(NTAP-2)) begin
                    state_nxt     = ST_RUN;
                    flush_cnt_nxt = '0;
                end else begin
                    flush_cnt_nxt = flush_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                if (cfg_cm) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                flush_cnt_nxt = '0;
            end
        endcase
    end

    // The datapath shifts every cycle, so anything other than an accepted
    // sample is fed as 0.0; this is also what flushes the delay line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_out     <= DW'(FP_ZERO);
            out_valid <= 1'b0;
        end else if (in_ready && in_valid) begin
            x_out     <= in_data;
            out_valid <= 1'b1;
        end else begin
            x_out     <= DW'(FP_ZERO);
            out_valid <= 1'b0;
        end
    end

    fir_coef_bank #(
        .NTAP (NTAP),
        .DW   (DW),
        .AW   (AW)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cfg_wr),
        .wr_addr  (cfg_addr),
        .wr_data  (cfg_data),
        .commit   (cfg_cm),
        .coef_out (coef_out)
    );

endmodule

// File: tb/tb_fir_tap_ctrl8.sv
// tb/tb_fir_tap_ctrl8.sv - self-checking bench for fir_tap_ctrl8
module tb_fir_tap_ctrl8;

    localparam logic [31:0] ONE = 32'h3F80_0000;
    localparam logic [31:0] TWO = 32'h4000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         cfg_valid;
    logic [2:0]   cfg_addr;
    logic [31:0]  cfg_data;
    logic         cfg_commit;
    logic         cfg_ready;
    logic [31:0]  x_out;
    logic [255:0] coef_out;
    logic         out_valid;
    logic         busy;

    always #5 clk = ~clk;

    fir_tap_ctrl8 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cfg_valid  (cfg_valid),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_ready  (cfg_ready),
        .x_out      (x_out),
        .coef_out   (coef_out),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    // Reference model: committed flag plus cycles of flush remaining.
    logic [31:0] shadow_m [8];
    logic [31:0] active_m [8];
    bit          committed;
    int          flush_left;
    logic [31:0] x_exp;
    logic        ov_exp;

    int nvec = 0;
    int nerr = 0;

    function automatic logic [255:0] pack_active();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = active_m[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            shadow_m[i] = '0;
            active_m[i] = '0;
        end
        committed  = 0;
        flush_left = 0;
        x_exp      = '0;
        ov_exp     = 1'b0;
    endtask

    task automatic chk_outputs(input string where);
        chk({where, ".x_out"},     256'(x_out),     256'(x_exp));
        chk({where, ".out_valid"}, 256'(out_valid), 256'(ov_exp));
        chk({where, ".busy"},      256'(busy),      256'(flush_left > 0));
        chk({where, ".coef_out"},  coef_out,        pack_active());
        chk({where, ".cfg_ready"}, 256'(cfg_ready), 256'(flush_left == 0));
        chk({where, ".in_ready"},  256'(in_ready),  256'(committed && flush_left == 0));
    endtask

    // Called with clk low; drives one cycle and checks after the edge.
    task automatic step(input logic iv, input logic [31:0] id, input logic cv,
                        input logic [2:0] ca, input logic [31:0] cd, input logic cc);
        bit crdy, irdy;
        in_valid   = iv;
        in_data    = id;
        cfg_valid  = cv;
        cfg_addr   = ca;
        cfg_data   = cd;
        cfg_commit = cc;
        crdy = (flush_left == 0);
        irdy = committed && (flush_left == 0);
        if (cv && crdy) shadow_m[ca] = cd;
        if (cc && crdy) begin
            for (int i = 0; i < 8; i++) active_m[i] = shadow_m[i];
            committed  = 1;
            flush_left = 7;
        end else if (flush_left > 0) begin
            flush_left--;
        end
        x_exp  = (iv && irdy) ? id : 32'h0;
        ov_exp = iv && irdy;
        @(posedge clk);
        @(negedge clk);
        chk_outputs("step");
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        cfg_valid  = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        cfg_commit = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_outputs("reset");
        rst = 1'b0;

        // IDLE: samples are not accepted
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 3'd0, 32'h0, 1'b0);

        // load 1.0 in all taps and commit, then ride out the flush
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 3'(i), ONE, 1'b0);
        step(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1);
        chk("coef_all_one", coef_out, {8{ONE}});
        for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, 3'd0, 32'h0, 1'b0);

        // stream and gaps
        for (int i = 0; i < 10; i++) step(1'b1, ONE, 1'b0, 3'd0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++)  step(1'b0, ONE, 1'b0, 3'd0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), $urandom, 1'b0, 3'd0, 32'h0, 1'b0);

        // write+commit same cycle with a sample in flight, then poke cfg during flush
        step(1'b1, 32'hC0DE_0001, 1'b1, 3'd3, TWO, 1'b1);
        chk("coef_b4_two", 256'(coef_out[127:96]), 256'(TWO));
        for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b1, 3'($urandom_range(0, 7)), $urandom, 1'b1);
        // shadow must be unchanged by the rejected writes
        step(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);

        // randomized mix
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom,
                 1'($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 19) == 0));
        end

        // reset mid-stream, then commit a freshly zeroed shadow
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 3'(i), $urandom | 32'h1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, 3'd0, 32'h0, 1'b0);
        step(1'b1, 32'h1234_5678, 1'b0, 3'd0, 32'h0, 1'b0);
        async_reset();
        step(1'b1, $urandom, 1'b0, 3'd0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 3'd0, 32'h0, 1'b0);

        // reset mid-flush
        async_reset();
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'($urandom_range(0, 1)),
                                         3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
